// File: rtl/mem_rdpack.sv
// Read-data assembler: gathers bytes returned by narrow memory cycles into a
// 64-bit accumulator and presents the right-justified result over valid/ready.
module mem_rdpack (
  input  logic        sys_clk,
  input  logic        resetl,
  input  logic        start,
  input  logic [3:0]  w,
  input  logic [2:0]  ba,
  input  logic        bigend,
  input  logic [1:0]  mw,
  input  logic [2:0]  at,
  input  logic [3:0]  maskw,
  input  logic        rack,
  input  logic [63:0] din,
  input  logic        dready,
  output logic [63:0] dout,
  output logic        dvalid,
  output logic        busy,
  output logic [1:0]  dbg_state_o
);

  // Handshake: dout is offered while dvalid=1 and is held unchanged until a
  // cycle with dvalid=1 and dready=1; that edge is the transfer of the result.

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_DONE    = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [63:0] acc_q, acc_d;
  logic [63:0] dout_q, dout_d;
  logic [3:0]  rc_q, rc_d;
  logic [3:0]  wl_q, wl_d;
  logic [2:0]  bal_q, bal_d;
  logic        bel_q, bel_d;

  logic [2:0]  lane_mask;
  logic [3:0]  w_norm;
  logic [63:0] acc_upd;
  logic [63:0] ord;
  logic [4:0]  rc_sum;
  logic [3:0]  rc_upd;
  logic [2:0]  addr, lane, offs, idx;

  always_ff @(posedge sys_clk or negedge resetl) begin
    if (!resetl) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      dout_q  <= '0;
      rc_q    <= '0;
      wl_q    <= '0;
      bal_q   <= '0;
      bel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      dout_q  <= dout_d;
      rc_q    <= rc_d;
      wl_q    <= wl_d;
      bal_q   <= bal_d;
      bel_q   <= bel_d;
    end
  end

  // Byte steering for the current cycle and the ordered result it would give.
  always_comb begin
    lane_mask = {&mw, mw[1], |mw};
    w_norm    = (w == 4'd0 || w > 4'd8) ? 4'd8 : w;
    acc_upd   = acc_q;
    addr      = '0;
    lane      = '0;
    offs      = '0;
    idx       = '0;
    for (int j = 0; j < 8; j++) begin
      addr = at + 3'(j);
      lane = addr & lane_mask;
      offs = addr - bal_q;
      if (4'(j) < maskw && {1'b0, offs} < wl_q)
        acc_upd[{offs, 3'b000} +: 8] = din[{lane, 3'b000} +: 8];
    end
    rc_sum = {1'b0, rc_q} + {1'b0, maskw};
    rc_upd = (rc_sum > 5'd8) ? 4'd8 : rc_sum[3:0];
    ord    = '0;
    for (int i = 0; i < 8; i++) begin
      idx = bel_q ? 3'(wl_q - 4'd1 - 4'(i)) : 3'(i);
      if (4'(i) < wl_q)
        ord[{idx, 3'b000} +: 8] = acc_upd[i*8 +: 8];
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    dout_d  = dout_q;
    rc_d    = rc_q;
    wl_d    = wl_q;
    bal_d   = bal_q;
    bel_d   = bel_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_COLLECT;
          wl_d = w_norm; bal_d = ba; bel_d = bigend; acc_d = '0; rc_d = '0;
        end
      end
      S_COLLECT: begin
        // A new start aborts the transfer in flight; its rack is dropped.
        if (start) begin
          wl_d = w_norm; bal_d = ba; bel_d = bigend; acc_d = '0; rc_d = '0;
        end else if (rack) begin
          acc_d = acc_upd;
          rc_d  = rc_upd;
          if (rc_upd >= wl_q) begin
            state_d = S_DONE;
            dout_d  = ord;
          end
        end
      end
      S_DONE: begin
        if (dready) begin
          if (start) begin
            state_d = S_COLLECT;
            wl_d = w_norm; bal_d = ba; bel_d = bigend; acc_d = '0; rc_d = '0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign dout        = dout_q;
  assign dvalid      = (state_q == S_DONE);
  assign busy        = (state_q != S_IDLE);
  assign dbg_state_o = state_q;

endmodule
